// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: I2C target that oversamples SCL/SDA on the system clock.
// It detects START, repeated START and STOP, ACKs its 7-bit address, delivers
// write bytes on rx_data/rx_valid and fetches read bytes through tx_req/tx_data.
// SDA is open drain: the block only ever pulls it low or releases it.
// Optional build macro I2C_SLAVE_GENERAL_CALL_EN: when defined, the general-call
// header 0x00 (address 0, write) is also ACKed and its data bytes delivered.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_d, sda_d;
    logic                   scl_rise, scl_fall;
    logic                   start_det, stop_det;
    logic [7:0]             shift_nxt;
    logic                   gc_hit;
    logic                   addr_ok;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rw;
    logic       sda_oe;

    // Open drain: pull low when enabled, otherwise float for the pull-up.
    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronizer chains; idle bus level is high, plus one delayed copy for edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SDA moving while SCL stays high marks a bus condition, never a data bit.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign shift_nxt = {shift_reg[6:0], sda_s};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    assign gc_hit = (shift_nxt == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif
    assign addr_ok = (shift_nxt[7:1] == SLAVE_ADDR) || gc_hit;

    // Protocol FSM: bus conditions first, then bit handling on SCL edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'h00;
            rw         <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= 4'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b1;
            end else if (stop_det) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                sda_oe     <= 1'b0;
                addr_match <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= shift_nxt;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd8;
                                rw      <= sda_s;
                                state   <= addr_ok ? ADDR_ACK : IGNORE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // ACK slot: count 8 = drive on next fall, 0 = 9th rise seen,
                    // so the following fall ends the slot.
                    ADDR_ACK, RX_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd0;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            if (state == ADDR_ACK) begin
                                addr_match <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd0) begin
                            if (state == ADDR_ACK && rw) begin
                                tx_req    <= 1'b1;
                                shift_reg <= tx_data;
                                sda_oe    <= ~tx_data[7];
                                state     <= TX;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= RX;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift_reg <= shift_nxt;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt  <= 4'd8;
                                rx_data  <= shift_nxt;
                                rx_valid <= 1'b1;
                                state    <= RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    // The bit on the wire is always shift_reg[7]; rotate on each fall.
                    TX: begin
                        if (scl_rise) begin
                            if (bit_cnt != 4'd8) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], shift_reg[7]};
                                sda_oe    <= ~shift_reg[6];
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd0;
                            if (sda_s) begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && bit_cnt == 4'd0) begin
                            tx_req    <= 1'b1;
                            shift_reg <= tx_data;
                            sda_oe    <= ~tx_data[7];
                            state     <= TX;
                        end
                    end
                    IGNORE: begin
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
